// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencing controller.
package led_pkg;

    localparam int unsigned LED_W = 8;
    localparam int unsigned POS_W = 3;
    localparam int unsigned LAP_W = 8;

    localparam logic [LED_W-1:0] LOAD_START = 8'h01;
    localparam logic [LED_W-1:0] LOAD_CLEAR = 8'h00;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [POS_W-1:0] POS_FIRST = '0;
    localparam logic [POS_W-1:0] POS_LAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ROL     = 2'b00,
        MODE_ROR     = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ALT_ROL = 2'b11
    } mode_e;

    // Code 11 behaves exactly like rotate-left, so it is folded at latch time.
    function automatic mode_e latch_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ROL : mode_e'(m);
    endfunction

    function automatic logic start_dir(input mode_e m);
        return (m == MODE_ROR) ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..DIV_MAX while running and flags the terminal count.
module tick_gen #(
    parameter int unsigned DIV_MAX = 24_999_999,
    parameter int unsigned CNT_W   = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic hold,
    input  logic clr,
    output logic tick_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    // hold only defers the wrap: the count parks at DIV_MAX and the step is kept pending.
    always_comb begin
        at_max = (cnt_q == CNT_W'(DIV_MAX));
        tick_c = run & ~hold & ~clr & at_max;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (!at_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!hold) begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Single-clock sequencing controller for the 8-LED shifter: button start/pause/resume,
// clear, prescaled step strobes, position and lap tracking.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DIV_MAX     = 24_999_999,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check,
    input  logic             clear,
    input  logic [1:0]       mode,
    output logic             load,
    output logic [LED_W-1:0] load_val,
    output logic             shift_en,
    output logic             shift_dir,
    output logic [POS_W-1:0] pos,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             busy
);

    logic [SYNC_STAGES-1:0] chk_sync_q, chk_sync_d;
    logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
    logic                   chk_prev_q, chk_prev_d;
    logic                   chk_ev_q, chk_ev_d;
    logic                   clr_prev_q, clr_prev_d;
    logic                   chk_s, clr_s, clr_rise;

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d, start_mode;
    logic                   dir_q, dir_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic [LAP_W-1:0]       lap_q, lap_d;
    logic                   load_q, load_d;
    logic [LED_W-1:0]       load_val_q, load_val_d;
    logic                   shift_en_q, shift_en_d;
    logic                   shift_dir_q, shift_dir_d;
    logic                   busy_q, busy_d;

    logic                   tg_run, tg_hold, tg_clr, tick_c;
    logic [POS_W-1:0]       step_pos;
    logic                   step_dir, step_wrap;

    // Input synchronisers; chk_ev is a registered one-cycle rising-edge pulse.
    always_comb begin
        chk_sync_d = {chk_sync_q[SYNC_STAGES-2:0], check};
        clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], clear};
        chk_s      = chk_sync_q[SYNC_STAGES-1];
        clr_s      = clr_sync_q[SYNC_STAGES-1];
        chk_prev_d = chk_s;
        chk_ev_d   = chk_s & ~chk_prev_q;
        clr_prev_d = clr_s;
        clr_rise   = clr_s & ~clr_prev_q;
    end

    always_comb begin
        tg_run  = (state_q == ST_RUN);
        tg_hold = chk_ev_q;
        tg_clr  = clr_s | (state_q == ST_IDLE);
    end

    tick_gen #(
        .DIV_MAX (DIV_MAX),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .run    (tg_run),
        .hold   (tg_hold),
        .clr    (tg_clr),
        .tick_c (tick_c)
    );

    // Next position/direction for one step of the latched pattern.
    always_comb begin
        step_pos  = pos_q;
        step_dir  = dir_q;
        step_wrap = 1'b0;
        case (mode_q)
            MODE_ROR: begin
                step_pos  = pos_q - POS_W'(1);
                step_wrap = (pos_q == POS_FIRST);
            end
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    step_pos = pos_q + POS_W'(1);
                    step_dir = (step_pos == POS_LAST) ? DIR_RIGHT : DIR_LEFT;
                end else begin
                    step_pos  = pos_q - POS_W'(1);
                    step_dir  = (step_pos == POS_FIRST) ? DIR_LEFT : DIR_RIGHT;
                    step_wrap = (step_pos == POS_FIRST);
                end
            end
            default: begin
                step_pos  = pos_q + POS_W'(1);
                step_wrap = (pos_q == POS_LAST);
            end
        endcase
    end

    always_comb begin : fsm_comb
        state_d     = state_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        lap_d       = lap_q;
        load_d      = 1'b0;
        load_val_d  = load_val_q;
        shift_en_d  = 1'b0;
        shift_dir_d = shift_dir_q;
        start_mode  = latch_mode(mode);

        if (clr_s) begin
            state_d = ST_IDLE;
            pos_d   = POS_FIRST;
            if (clr_rise) begin
                load_d     = 1'b1;
                load_val_d = LOAD_CLEAR;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chk_ev_q) begin
                        state_d     = ST_RUN;
                        load_d      = 1'b1;
                        load_val_d  = LOAD_START;
                        pos_d       = POS_FIRST;
                        mode_d      = start_mode;
                        dir_d       = start_dir(start_mode);
                        shift_dir_d = start_dir(start_mode);
                    end
                end
                ST_RUN: begin
                    // A coincident tick is held inside the prescaler, not lost.
                    if (chk_ev_q) begin
                        state_d = ST_PAUSE;
                    end else if (tick_c) begin
                        shift_en_d  = 1'b1;
                        shift_dir_d = dir_q;
                        pos_d       = step_pos;
                        dir_d       = step_dir;
                        lap_d       = lap_q + LAP_W'(step_wrap);
                    end
                end
                ST_PAUSE: begin
                    if (chk_ev_q) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_sync_q  <= '0;
            clr_sync_q  <= '0;
            chk_prev_q  <= 1'b0;
            chk_ev_q    <= 1'b0;
            clr_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ROL;
            dir_q       <= DIR_LEFT;
            pos_q       <= '0;
            lap_q       <= '0;
            load_q      <= 1'b0;
            load_val_q  <= '0;
            shift_en_q  <= 1'b0;
            shift_dir_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            chk_sync_q  <= chk_sync_d;
            clr_sync_q  <= clr_sync_d;
            chk_prev_q  <= chk_prev_d;
            chk_ev_q    <= chk_ev_d;
            clr_prev_q  <= clr_prev_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            lap_q       <= lap_d;
            load_q      <= load_d;
            load_val_q  <= load_val_d;
            shift_en_q  <= shift_en_d;
            shift_dir_q <= shift_dir_d;
            busy_q      <= busy_d;
        end
    end

    assign load      = load_q;
    assign load_val  = load_val_q;
    assign shift_en  = shift_en_q;
    assign shift_dir = shift_dir_q;
    assign pos       = pos_q;
    assign lap_cnt   = lap_q;
    assign busy      = busy_q;

endmodule
